// File: rtl/chart_sequencer.sv
// Chart sequencer: plays a step-chart ROM at a fixed number of frame ticks per
// row and hands each non-empty row to the arrow field on a valid/ready handshake.
module chart_sequencer #(
    parameter int ROM_AW        = 10,
    parameter int TICKS_PER_ROW = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              pause,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              spawn_valid,
    output logic [3:0]        spawn_lanes,
    input  logic              spawn_ready,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] row_count,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, READ, EVAL, HOLD, WAIT, DONE} state_t;

    localparam logic [ROM_AW-1:0] ADDR_MAX  = '1;
    localparam logic [7:0]        TICK_LAST = 8'(TICKS_PER_ROW - 1);

    state_t     state, state_nx;
    logic       frame_clk_d, fe, tick, row_due, row_pend;
    logic [7:0] tick_cnt;
    logic       go, count_row, load_spawn, drop_spawn, set_ovf;
    logic       adv, step_addr, consume_pend, finish;
    logic [2:0] rsvd_unused;

    assign rsvd_unused = rom_data[7:5];

    assign fe      = frame_clk & ~frame_clk_d;
    assign tick    = fe & ~pause & busy;
    assign row_due = tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge Clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        go           = 1'b0;
        count_row    = 1'b0;
        load_spawn   = 1'b0;
        drop_spawn   = 1'b0;
        set_ovf      = 1'b0;
        adv          = 1'b0;
        step_addr    = 1'b0;
        consume_pend = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    go       = 1'b1;
                    state_nx = READ;
                end
            end
            READ: state_nx = EVAL;
            EVAL: begin
                if (rom_data[4]) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else begin
                    count_row = 1'b1;
                    if (rom_data[3:0] != 4'd0) begin
                        load_spawn = 1'b1;
                        state_nx   = HOLD;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            HOLD: begin
                // A ready that coincides with the deadline still counts as accepted.
                if (spawn_ready || row_due) begin
                    drop_spawn = 1'b1;
                    if (row_due) begin
                        set_ovf = ~spawn_ready;
                        adv     = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (row_due || row_pend) begin
                    consume_pend = 1'b1;
                    adv          = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (adv) begin
            if (rom_addr == ADDR_MAX) begin
                finish   = 1'b1;
                state_nx = DONE;
            end else begin
                step_addr = 1'b1;
                state_nx  = READ;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            frame_clk_d <= 1'b0;
            tick_cnt    <= 8'd0;
            row_pend    <= 1'b0;
            rom_addr    <= '0;
            row_count   <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_lanes <= 4'd0;
        end else begin
            frame_clk_d <= frame_clk;

            if (go)        tick_cnt <= 8'd0;
            else if (tick) tick_cnt <= row_due ? 8'd0 : tick_cnt + 8'd1;

            // A deadline that lands while a row is still being fetched is remembered.
            if (go)                                              row_pend <= 1'b0;
            else if (row_due && state != WAIT && state != HOLD) row_pend <= 1'b1;
            else if (consume_pend)                              row_pend <= 1'b0;

            if (go) begin
                rom_addr  <= '0;
                row_count <= '0;
                overflow  <= 1'b0;
                done      <= 1'b0;
                busy      <= 1'b1;
            end
            if (step_addr) rom_addr <= rom_addr + 1'b1;
            if (count_row && row_count != ADDR_MAX) row_count <= row_count + 1'b1;
            if (set_ovf) overflow <= 1'b1;

            if (load_spawn) begin
                spawn_valid <= 1'b1;
                spawn_lanes <= rom_data[3:0];
            end else if (drop_spawn) begin
                spawn_valid <= 1'b0;
            end

            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: directed and random charts checked against a
// row/deadline-level model of when each spawn and the end of play must occur.
module tb_chart_sequencer;
    localparam int AW   = 3;
    localparam int TPR  = 2;
    localparam int ROWS = 1 << AW;

    logic          Clk = 1'b0;
    logic          reset = 1'b0, frame_clk = 1'b0, start = 1'b0, pause = 1'b0, spawn_ready = 1'b0;
    logic [AW-1:0] rom_addr, row_count;
    logic [7:0]    rom_data;
    logic          spawn_valid, busy, done, overflow;
    logic [3:0]    spawn_lanes;
    logic [7:0]    rom [ROWS];

    chart_sequencer #(.ROM_AW(AW), .TICKS_PER_ROW(TPR)) dut (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .start(start), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data), .spawn_valid(spawn_valid),
        .spawn_lanes(spawn_lanes), .spawn_ready(spawn_ready), .busy(busy), .done(done),
        .row_count(row_count), .overflow(overflow)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[rom_addr];

    int n_assert = 0, n_fail = 0, cyc = 0;
    int start_cyc = 0, done_cyc = -1, tb_ticks = 0, p_period = 6, f_phase = 0;
    int ready_mode = 1, vcnt = 0, pause_left = 0;
    bit pause_rand = 0, counting = 0;
    logic ready_man = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    logic [3:0] prev_lanes = 4'd0;
    int rise_q[$], due_q[$];
    logic [3:0] rise_lanes_q[$], acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, check the handshake, then drive the next inputs.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (reset && prev_valid) begin
            if (prev_ready) begin
                acc_q.push_back(prev_lanes);
                chk("one_outstanding", spawn_valid, 0);
            end else if (spawn_valid) begin
                chk("lanes_stable", spawn_lanes, prev_lanes);
            end else begin
                chk("drop_needs_overflow", overflow, 1);
            end
        end
        if (spawn_valid && !prev_valid) begin
            rise_q.push_back(cyc);
            rise_lanes_q.push_back(spawn_lanes);
        end
        if (done && !prev_done) done_cyc = cyc;
        vcnt       = spawn_valid ? vcnt + 1 : 0;
        prev_valid = spawn_valid;
        prev_lanes = spawn_lanes;
        prev_done  = done;

        start = 1'b0;
        pause = pause_rand ? ($urandom_range(3) == 0) : (pause_left > 0);
        f_phase   = (f_phase + 1) % p_period;
        frame_clk = (f_phase == 0);
        if (frame_clk && counting && !pause) begin
            tb_ticks++;
            if (tb_ticks % TPR == 0) due_q.push_back(cyc);
        end
        if (frame_clk && pause && pause_left > 0) pause_left--;
        case (ready_mode)
            0:       spawn_ready = spawn_valid ? (vcnt >= 3 || $urandom_range(1) == 1) : ($urandom_range(1) == 1);
            1:       spawn_ready = 1'b1;
            default: spawn_ready = ready_man;
        endcase
        prev_ready = spawn_ready;
    endtask

    task automatic do_start();
        start     = 1'b1;
        start_cyc = cyc;
        counting  = 1;
        tb_ticks  = 0;
        done_cyc  = -1;
        due_q.delete();
        rise_q.delete();
        rise_lanes_q.delete();
        acc_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !(i > 0 && spawn_valid); i++) step();
        chk({tag, ".valid_seen"}, spawn_valid, 1);
    endtask

    task automatic finish_play(input string tag);
        for (int i = 0; i < 800 && done_cyc < 0; i++) step();
        chk({tag, ".done_seen"}, (done_cyc >= 0), 1);
    endtask

    // Row k is fetched at start (k=0) or at the k-th deadline; its spawn shows 3 clocks later.
    task automatic check_play(input string tag, input logic [7:0] noacc, input logic exp_ovf);
        int er[$];
        logic [3:0] el[$], ea[$];
        int rc, t, exp_done, exp_addr, n;
        rc = 0; exp_done = -100; exp_addr = 0;
        for (int k = 0; k < ROWS; k++) begin
            if (k == 0)                t = start_cyc;
            else if (due_q.size() >= k) t = due_q[k-1];
            else                        t = -1000;
            exp_addr = k;
            if (rom[k][4]) begin
                exp_done = t + 3;
                break;
            end
            if (rc < ROWS - 1) rc++;
            if (rom[k][3:0] != 4'd0) begin
                er.push_back(t + 3);
                el.push_back(rom[k][3:0]);
                if (!noacc[k]) ea.push_back(rom[k][3:0]);
            end
            if (k == ROWS - 1) exp_done = (due_q.size() >= ROWS) ? due_q[ROWS-1] + 1 : -1000;
        end
        chk({tag, ".n_spawn"}, rise_q.size(), er.size());
        n = (rise_q.size() < er.size()) ? rise_q.size() : er.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.spawn%0d_cyc", tag, i), rise_q[i], er[i]);
            chk($sformatf("%s.spawn%0d_lanes", tag, i), rise_lanes_q[i], el[i]);
        end
        chk({tag, ".n_accept"}, acc_q.size(), ea.size());
        n = (acc_q.size() < ea.size()) ? acc_q.size() : ea.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s.accept%0d", tag, i), acc_q[i], ea[i]);
        chk({tag, ".done_cyc"}, done_cyc, exp_done);
        chk({tag, ".row_count"}, row_count, rc);
        chk({tag, ".rom_addr"}, rom_addr, exp_addr);
        chk({tag, ".overflow"}, overflow, exp_ovf);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".valid"}, spawn_valid, 0);
    endtask

    task automatic load_rom(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
        for (int i = 0; i < ROWS; i++) rom[i] = 8'h00;
        rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, spawn_valid, 0);
        chk({tag, ".lanes"}, spawn_lanes, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".row_count"}, row_count, 0);
        chk({tag, ".rom_addr"}, rom_addr, 0);
        chk({tag, ".overflow"}, overflow, 0);
    endtask

    initial begin
        load_rom(8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();

        // two spawns a row apart, end marker on row 2
        load_rom(8'h01, 8'h06, 8'h10, 8'h00);
        ready_mode = 1;
        do_start();
        finish_play("basic");
        check_play("basic", 8'h00, 1'b0);

        // command held unaccepted for 5 clocks, then a single ready pulse
        load_rom(8'h0F, 8'h10, 8'h00, 8'h00);
        p_period = 10; ready_mode = 2; ready_man = 1'b0;
        do_start();
        wait_valid("hold");
        repeat (5) step();
        chk("hold.still_valid", spawn_valid, 1);
        chk("hold.lanes", spawn_lanes, 4'hF);
        ready_man = 1'b1;
        step();
        ready_man = 1'b0;
        finish_play("hold");
        check_play("hold", 8'h00, 1'b0);

        // row deadline passes with no ready
        load_rom(8'h03, 8'h05, 8'h10, 8'h00);
        ready_mode = 2; ready_man = 1'b0;
        do_start();
        wait_valid("ovf");
        for (int i = 0; i < 40 && spawn_valid; i++) step();
        chk("ovf.dropped", spawn_valid, 0);
        chk("ovf.flag", overflow, 1);
        chk("ovf.addr_adv", rom_addr, 1);
        ready_mode = 0;
        finish_play("ovf");
        check_play("ovf", 8'h01, 1'b1);

        // empty row, pause over 4 frame edges, and a start pulse while busy
        load_rom(8'h08, 8'h00, 8'h08, 8'h10);
        p_period = 6; ready_mode = 1;
        do_start();
        wait_valid("pause");
        pause_left = 4;
        start = 1'b1;
        step();
        chk("pause.busy", busy, 1);
        finish_play("pause");
        check_play("pause", 8'h00, 1'b0);
        chk("pause.drained", pause_left, 0);

        // end marker on row 0
        load_rom(8'h1F, 8'h01, 8'h01, 8'h01);
        do_start();
        finish_play("endrow0");
        check_play("endrow0", 8'h00, 1'b0);

        // implicit end at the last ROM row, reserved bits set on some rows
        for (int i = 0; i < ROWS; i++) rom[i] = (i % 2 == 1) ? 8'hE2 : 8'h02;
        ready_mode = 0;
        do_start();
        finish_play("implicit");
        check_play("implicit", 8'h00, 1'b0);

        // reset while a command is held
        load_rom(8'h04, 8'h10, 8'h00, 8'h00);
        ready_mode = 2; ready_man = 1'b0;
        do_start();
        wait_valid("rst_hold");
        reset = 1'b0;
        step();
        chk_all_zero("rst_hold");
        reset = 1'b1;
        repeat (3) step();
        chk("rst_hold.idle_valid", spawn_valid, 0);
        chk("rst_hold.idle_busy", busy, 0);

        // random charts, random ready timing, random pause
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < ROWS; i++) begin
                rom[i][3:0] = 4'($urandom_range(15));
                rom[i][4]   = ($urandom_range(9) == 0);
                rom[i][7:5] = 3'($urandom_range(7));
            end
            p_period   = $urandom_range(9, 6);
            pause_rand = 1;
            ready_mode = 0;
            do_start();
            finish_play($sformatf("rand%0d", it));
            check_play($sformatf("rand%0d", it), 8'h00, 1'b0);
        end
        pause_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
